// File: rtl/proc_pkg.sv
// Shared types and defaults for the pulse dispatch slice.
package proc_pkg;

  localparam int PULSE_OUT_WIDTH = 72;
  localparam int TS_WIDTH        = 32;
  localparam int CHAN_WIDTH      = 2;

  // How a command whose fire time has already passed is treated.
  typedef enum logic {
    LATE_DROP = 1'b0,
    LATE_FIRE = 1'b1
  } late_mode_t;

  // Buffered pulse command at default widths. "time" is a keyword, hence fire_time.
  typedef struct packed {
    logic [TS_WIDTH-1:0]        fire_time;
    logic [CHAN_WIDTH-1:0]      chan;
    logic [PULSE_OUT_WIDTH-1:0] data;
  } pulse_entry_t;

endpackage

// File: rtl/cmd_fifo.sv
// Power-of-two circular command buffer with synchronous flush and occupancy count.
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  import proc_pkg::*;

  localparam int PW    = $clog2(DEPTH);
  localparam int CNT_W = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem[rd_ptr_q];

  // Qualify requests against occupancy; flush overrides both.
  always_comb begin
    push_ok = push && !flush && (count_q < CNT_W'(DEPTH));
    pop_ok  = pop  && !flush && !empty;
  end

  // Pointer and count next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/pulse_dispatch.sv
// Time-triggered pulse dispatcher: buffers commands and fires each on its qclk match.
module pulse_dispatch #(
  parameter int DATA_WIDTH      = 32,
  parameter int PULSE_OUT_WIDTH = 72,
  parameter int N_CHAN          = 4,
  parameter int FIFO_DEPTH      = 8,
  parameter int LATE_MODE       = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [DATA_WIDTH-1:0]               qclk,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [DATA_WIDTH-1:0]               cmd_time,
  input  logic [((N_CHAN > 1) ? $clog2(N_CHAN) : 1)-1:0] cmd_chan,
  input  logic [PULSE_OUT_WIDTH-1:0]          cmd_data,
  input  logic                                flush,
  input  logic                                late_clr,
  output logic [N_CHAN*PULSE_OUT_WIDTH-1:0]   cmd_out,
  output logic [N_CHAN-1:0]                   cstrobe_out,
  output logic                                late_err,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_count
);
  import proc_pkg::*;

  localparam int CW    = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam late_mode_t MODE = (LATE_MODE != 0) ? LATE_FIRE : LATE_DROP;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]      fire_time;
    logic [CW-1:0]              chan;
    logic [PULSE_OUT_WIDTH-1:0] data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  entry_t                            wr_entry, head;
  logic [ENTRY_W-1:0]                head_raw;
  logic                              fifo_empty;
  logic                              push, pop;
  logic                              ready_en_q;
  logic [DATA_WIDTH-1:0]             diff;
  logic                              due, late, chan_ok, fire, err_evt;
  logic [N_CHAN-1:0]                 strobe_q, strobe_d;
  logic [N_CHAN*PULSE_OUT_WIDTH-1:0] out_q, out_d;
  logic                              late_err_q, late_err_d;

  assign cmd_ready   = ready_en_q && (fifo_count < CNT_W'(FIFO_DEPTH)) && !flush;
  assign push        = cmd_valid && cmd_ready;
  assign wr_entry    = '{fire_time: cmd_time, chan: cmd_chan, data: cmd_data};
  assign head        = head_raw;
  assign cmd_out     = out_q;
  assign cstrobe_out = strobe_q;
  assign late_err    = late_err_q;

  cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wr_entry),
    .rdata (head_raw),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Head classification: wrap-aware signed distance from the head's fire time.
  always_comb begin
    diff    = qclk - head.fire_time;
    due     = (diff == '0);
    late    = !diff[DATA_WIDTH-1] && !due;
    chan_ok = int'(head.chan) < N_CHAN;
    pop     = !fifo_empty && !flush && (due || late);
    fire    = pop && chan_ok && (due || (MODE == LATE_FIRE));
    err_evt = pop && (late || !chan_ok);
  end

  // Strobe decode and per-channel payload hold.
  always_comb begin
    strobe_d = '0;
    out_d    = out_q;
    for (int unsigned k = 0; k < N_CHAN; k++) begin
      if (fire && (head.chan == CW'(k))) begin
        strobe_d[k] = 1'b1;
        out_d[k*PULSE_OUT_WIDTH +: PULSE_OUT_WIDTH] = head.data;
      end
    end
  end

  // Sticky late flag; a late event beats a same-cycle clear.
  always_comb begin
    late_err_d = late_err_q;
    if (err_evt)       late_err_d = 1'b1;
    else if (late_clr) late_err_d = 1'b0;
  end

  // Output and status registers; ready is held low until the first edge out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      strobe_q   <= '0;
      out_q      <= '0;
      late_err_q <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      strobe_q   <= strobe_d;
      out_q      <= out_d;
      late_err_q <= late_err_d;
      ready_en_q <= 1'b1;
    end
  end

endmodule

// File: doc/pulse_dispatch.md
PULSE_DISPATCH -- requirements
Module: pulse_dispatch

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the timestamp and qclk width.
REQ-002 The block SHALL have parameter PULSE_OUT_WIDTH, default 72, meaning the pulse command payload width.
REQ-003 The block SHALL have parameter N_CHAN, default 4, meaning the number of pulse output channels (at least 1).
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 8, meaning the command buffer depth (a power of 2, at least 2).
REQ-005 The block SHALL have parameter LATE_MODE, default 0, meaning late-command handling: 0 = drop, 1 = fire immediately.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic rises on it.
REQ-007 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-008 The block SHALL have port qclk, input, DATA_WIDTH: the current qclk count.
REQ-009 The block SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-010 The block SHALL have port cmd_ready, output, 1 bit: the buffer can accept a command.
REQ-011 The block SHALL have port cmd_time, input, DATA_WIDTH: the qclk value at which to fire.
REQ-012 The block SHALL have port cmd_chan, input, CW = max(1, clog2(N_CHAN)): the destination channel.
REQ-013 The block SHALL have port cmd_data, input, PULSE_OUT_WIDTH: the pulse payload.
REQ-014 The block SHALL have port flush, input, 1 bit: discard all buffered commands.
REQ-015 The block SHALL have port late_clr, input, 1 bit: clear late_err.
REQ-016 The block SHALL have port cmd_out, output, N_CHAN*PULSE_OUT_WIDTH: per-channel held payload; channel k occupies slice [k*PULSE_OUT_WIDTH +: PULSE_OUT_WIDTH].
REQ-017 The block SHALL have port cstrobe_out, output, N_CHAN: per-channel one-cycle fire strobe.
REQ-018 The block SHALL have port late_err, output, 1 bit: sticky late-command flag.
REQ-019 The block SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1: the number of buffered commands.

Function
REQ-020 cmd_ready SHALL equal (fifo_count < FIFO_DEPTH) AND NOT flush, with no combinational path from cmd_valid.
REQ-021 A command SHALL be accepted on a rising clk with cmd_valid AND cmd_ready, and SHALL be eligible at the head no earlier than the next cycle.
REQ-022 With the buffer empty, no comparison SHALL occur and cstrobe_out SHALL be 0.
REQ-023 The head entry is "due" when qclk == head.time; due SHALL cause a pop, and on the next cycle cstrobe_out[head.chan] = 1 (exactly one bit) and that channel's cmd_out = head.data.
REQ-024 The head entry is "late" when signed(qclk - head.time) > 0, a modulo 2^DATA_WIDTH, wrap-aware difference.
REQ-025 A late head SHALL be popped and SHALL set late_err.
REQ-026 For a late head, LATE_MODE=0 SHALL produce no strobe and leave cmd_out unchanged; LATE_MODE=1 SHALL strobe as in REQ-023.
REQ-027 A head that is neither due nor late SHALL wait with no pop.
REQ-028 At most one pop SHALL occur per cycle; a second entry with the same time is therefore late and SHALL follow REQ-024 to REQ-026.
REQ-029 Each channel's cmd_out SHALL hold its last payload until that channel strobes again; channels not strobing SHALL be unaffected.
REQ-030 cmd_chan >= N_CHAN SHALL be accepted; on its pop the entry SHALL be discarded with no strobe, and late_err SHALL be set.
REQ-031 A push and a pop in the same cycle SHALL leave fifo_count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 flush SHALL empty the buffer on the next edge, suppress any pop and strobe in that cycle, and leave cmd_out and late_err unchanged.
REQ-033 late_clr SHALL clear late_err; a late event in the same cycle SHALL win, leaving late_err = 1.

Reset
REQ-034 While reset = 0: cstrobe_out = 0, cmd_out = 0, late_err = 0, fifo_count = 0, cmd_ready = 0, and pointers = 0.
REQ-035 Reset asserted mid-operation SHALL discard all entries immediately, with no strobe on release.
REQ-036 cmd_ready SHALL rise on the first edge after reset deasserts.

Structure
REQ-037 Package proc_pkg SHALL hold PULSE_OUT_WIDTH, the late_mode_t enum (LATE_DROP, LATE_FIRE) and the pulse_entry_t struct {time, chan, data}.
REQ-038 The buffer SHALL be sub-module cmd_fifo (parametrised width and depth, with push, pop, flush and count); compare, strobe and late logic SHALL live in pulse_dispatch.

Verification
REQ-039 The bench SHALL cover: push {time=100, chan=2, data=A}, qclk ramps from 90 -> cstrobe_out = 4'b0100 for one cycle at the edge after qclk=100, and cmd_out slice 2 = A held.
REQ-040 The bench SHALL cover: push 8 commands with time=1000 while qclk=0 -> cmd_ready = 0 and fifo_count = 8; a 9th cmd_valid is not accepted.
REQ-041 The bench SHALL cover: with LATE_MODE=0, push time=5 while qclk=10 -> entry popped, no strobe, late_err = 1; late_clr -> late_err = 0. With LATE_MODE=1 -> strobe fires.
REQ-042 The bench SHALL cover wrap: push time=0x00000002 while qclk=0xFFFFFFFE -> not late; strobe when qclk=2.
REQ-043 The bench SHALL cover: two entries at time=50 -> first strobes, second is late.
REQ-044 The bench SHALL cover: flush with 3 entries queued, and reset asserted mid-run -> fifo_count = 0, no strobes, cmd_out retained after flush and zeroed after reset.
